// File: rtl/ser_pkg.sv
// ser_pkg: shared FSM state encoding and frame-overhead constant for the serial framer
package ser_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int FRAME_OVERHEAD = 3;
endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: bit-period counter that ticks on the last cycle of every bit period
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == CW'(CLKS_PER_BIT - 1);
  // wrap at the end of each period; clear holds the count at zero while the line idles
  always_comb cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  // count register
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/serial_tx_framer.sv
// serial_tx_framer: start + LSB-first payload + even parity + stop serializer with registered line
module serial_tx_framer
  import ser_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             busy,
  output logic             done
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             par_q, par_d, sdo_q, sdo_d, tick;
  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == IDLE),
    .tick  (tick)
  );
  assign load_ready = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign done       = state_q == STOP && tick;
  assign sdo        = sdo_q;
  // next state; the line value is derived from the next state so sdo is a plain register
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    case (state_q)
      IDLE: if (load_valid) begin
        state_d = START;
        shift_d = data_in;
        par_d   = ^data_in;
        idx_d   = '0;
      end
      START:  if (tick) state_d = DATA;
      DATA: if (tick) begin
        if (idx_q == IW'(WIDTH - 1)) state_d = PARITY;
        else begin
          idx_d   = idx_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP: if (tick) begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    sdo_d = state_d == START  ? 1'b0 :
            state_d == DATA   ? shift_d[0] :
            state_d == PARITY ? par_d : 1'b1;
  end
  // state, payload and line registers; reset wins over a same-edge accept
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      sdo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      sdo_q   <= sdo_d;
    end
endmodule

// File: tb/tb_serial_tx_framer.sv
// tb_serial_tx_framer: frame-level model check plus directed literal checks for two configurations
module tb_serial_tx_framer;
  import ser_pkg::*;
  localparam int NA = (8 + FRAME_OVERHEAD) * 4;
  localparam int NB = (4 + FRAME_OVERHEAD) * 1;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] data_a = '0;
  logic [3:0] data_b = '0;
  logic lv_a = 1'b0, lv_b = 1'b0;
  logic ready_a, sdo_a, busy_a, done_a, ready_b, sdo_b, busy_b, done_b;
  int tests = 0, errors = 0;
  bit chk_en = 1'b0;
  int ka = 0, kb = 0;
  logic [31:0] wa = '0, wb = '0;
  logic sa [0:99], ba [0:99], da [0:99], ra [0:99];
  logic sb [0:15], bb [0:15], db [0:15], rb [0:15];
  logic [10:0] fa5 = {1'b1, 1'b0, 8'hA5, 1'b0};
  logic [6:0]  ffb = {1'b1, 1'b0, 4'hF, 1'b0};
  int n;

  serial_tx_framer #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .load_valid(lv_a),
    .load_ready(ready_a), .sdo(sdo_a), .busy(busy_a), .done(done_a));
  serial_tx_framer #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .load_valid(lv_b),
    .load_ready(ready_b), .sdo(sdo_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // line value k cycles into a frame (k=0 means idle): start, payload LSB first, even parity, stop
  function automatic logic exp_sdo(int k, logic [31:0] w, int wd, int c);
    int p;
    if (k == 0) return 1'b1;
    p = (k - 1) / c;
    if (p == 0) return 1'b0;
    if (p <= wd) return w[p-1];
    if (p == wd + 1) return ^w;
    return 1'b1;
  endfunction

  // frame-position model: k counts cycles since the accept edge
  always @(posedge clk) begin
    if (rst) ka = 0;
    else if (ka == 0 && lv_a) begin ka = 1; wa = 32'(data_a); end
    else if (ka == NA) ka = 0;
    else if (ka != 0) ka++;
    if (rst) kb = 0;
    else if (kb == 0 && lv_b) begin kb = 1; wb = 32'(data_b); end
    else if (kb == NB) kb = 0;
    else if (kb != 0) kb++;
  end

  always @(negedge clk) if (chk_en) begin
    chk("a_sdo", 32'(sdo_a), 32'(exp_sdo(ka, wa, 8, 4)));
    chk("a_busy", 32'(busy_a), 32'(ka != 0));
    chk("a_done", 32'(done_a), 32'(ka == NA));
    chk("a_ready", 32'(ready_a), 32'(ka == 0));
    chk("b_sdo", 32'(sdo_b), 32'(exp_sdo(kb, wb, 4, 1)));
    chk("b_busy", 32'(busy_b), 32'(kb != 0));
    chk("b_done", 32'(done_b), 32'(kb == NB));
    chk("b_ready", 32'(ready_b), 32'(kb == 0));
  end

  task automatic rec(int i);
    sa[i] = sdo_a; ba[i] = busy_a; da[i] = done_a; ra[i] = ready_a;
    if (i < 16) begin sb[i] = sdo_b; bb[i] = busy_b; db[i] = done_b; rb[i] = ready_b; end
  endtask

  function automatic int count_a(int sel, int lo, int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++)
      c += sel == 0 ? int'(ba[i]) : sel == 1 ? int'(da[i]) : int'(!sa[i]);
    return c;
  endfunction

  function automatic int first_done_a(int lo, int hi);
    for (int i = lo; i <= hi; i++) if (da[i]) return i;
    return -1;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_sdo", 32'(sdo_a), 1);
    chk("rst_ready", 32'(ready_a), 1);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    rst = 1'b0;
    lv_a = 1'b1; data_a = 8'hA5;
    for (int i = 1; i <= 46; i++) begin
      @(negedge clk); rec(i);
      if (i == 1) begin lv_a = 1'b0; data_a = 8'hFF; end
      if (i == 10) lv_a = 1'b1;
      if (i == 20) lv_a = 1'b0;
    end
    for (int i = 1; i <= 44; i++) chk("a5_bit", 32'(sa[i]), 32'(fa5[(i-1)/4]));
    chk("a5_done_cycle", 32'(first_done_a(1, 46)), 44);
    chk("a5_done_count", 32'(count_a(1, 1, 46)), 1);
    chk("a5_ready_45", 32'(ra[45]), 1);
    chk("a5_busy_cycles", 32'(count_a(0, 1, 46)), 44);
    lv_a = 1'b1; data_a = 8'h07;
    for (int i = 1; i <= 46; i++) begin
      @(negedge clk); rec(i);
      if (i == 1) lv_a = 1'b0;
    end
    for (int i = 37; i <= 40; i++) chk("p07_parity", 32'(sa[i]), 1);
    chk("p07_busy_cycles", 32'(count_a(0, 1, 46)), 44);
    lv_a = 1'b1; data_a = 8'h11;
    for (int i = 1; i <= 92; i++) begin
      @(negedge clk); rec(i);
      if (i == 1) data_a = 8'h22;
      if (i == 46) lv_a = 1'b0;
    end
    chk("b2b_first_done", 32'(first_done_a(1, 92)), 44);
    chk("b2b_idle_sdo", 32'(sa[45]), 1);
    chk("b2b_idle_busy", 32'(ba[45]), 0);
    chk("b2b_idle_ready", 32'(ra[45]), 1);
    chk("b2b_start2", 32'(sa[46]), 0);
    chk("b2b_bit0_of_22", 32'(sa[50]), 0);
    chk("b2b_bit1_of_22", 32'(sa[54]), 1);
    chk("b2b_second_done", 32'(first_done_a(45, 92)), 89);
    lv_a = 1'b1; data_a = 8'h3C;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk); rec(i);
      if (i == 1) lv_a = 1'b0;
      if (i == 20) rst = 1'b1;
      if (i == 21) rst = 1'b0;
    end
    chk("abort_busy_before", 32'(ba[20]), 1);
    chk("abort_sdo", 32'(sa[21]), 1);
    chk("abort_busy", 32'(ba[21]), 0);
    chk("abort_ready", 32'(ra[21]), 1);
    chk("abort_no_done", 32'(count_a(1, 1, 30)), 0);
    rst = 1'b1; lv_a = 1'b1; data_a = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); rec(i);
      if (i == 1) begin rst = 1'b0; lv_a = 1'b0; end
    end
    chk("rst_accept_busy", 32'(count_a(0, 1, 8)), 0);
    chk("rst_accept_zeros", 32'(count_a(2, 1, 8)), 0);
    lv_b = 1'b1; data_b = 4'hF;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk); rec(i);
      if (i == 1) lv_b = 1'b0;
    end
    for (int i = 1; i <= 7; i++) chk("c1_bit", 32'(sb[i]), 32'(ffb[i-1]));
    n = 0;
    for (int i = 1; i <= 9; i++) n += int'(db[i]);
    chk("c1_done_count", 32'(n), 1);
    chk("c1_done_at_7", 32'(db[7]), 1);
    chk("c1_idle_sdo", 32'(sb[8]), 1);
    chk("c1_idle_ready", 32'(rb[8]), 1);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/serial_tx_framer.md
SERIAL_TX_FRAMER -- requirements
Module: serial_tx_framer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the payload bits per frame (range 1..32).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the clock cycles each line bit is held (range 1..65535).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it SHALL be synchronous and active-high.
REQ-005 The block SHALL have port data_in, input, WIDTH, the payload word, sampled only on an accepted load.
REQ-006 The block SHALL have port load_valid, input, 1, meaning the source presents a word on data_in.
REQ-007 The block SHALL have port load_ready, output, 1, meaning the block will accept a word this cycle.
REQ-008 The block SHALL have port sdo, output, 1, the registered serial line (idle level 1).
REQ-009 The block SHALL have port busy, output, 1, high while a frame is on the line.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse marking the last cycle of a frame.

Function
REQ-011 A load SHALL be accepted on a rising edge where load_valid and load_ready are both 1; data_in SHALL be captured into an internal shift register at that edge.
REQ-012 load_ready SHALL be 1 only in state IDLE and SHALL NOT depend combinationally on load_valid.
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-014 The FSM SHALL go IDLE->START on accept; START->DATA, DATA->PARITY (after WIDTH bits), PARITY->STOP, each after CLKS_PER_BIT cycles; and STOP->IDLE after CLKS_PER_BIT cycles.
REQ-015 sdo SHALL be 1 in IDLE and STOP, 0 in START, the current payload bit (LSB first) in DATA, and the even-parity bit (XOR of all WIDTH payload bits) in PARITY.
REQ-016 sdo SHALL change at the accept edge; the start bit SHALL be visible in the cycle after acceptance.
REQ-017 Every line bit SHALL be held for exactly CLKS_PER_BIT cycles, so one frame SHALL occupy (WIDTH+3)*CLKS_PER_BIT cycles.
REQ-018 A bit-cycle counter SHALL count 0..CLKS_PER_BIT-1 and wrap; a bit index SHALL count 0..WIDTH-1 in DATA.
REQ-019 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle with no skipped or repeated bits.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 done SHALL be 1 only during the final cycle of STOP; in the next cycle the state SHALL be IDLE with load_ready=1.
REQ-022 Back-to-back frames SHALL be separated by at least one IDLE cycle, in which sdo=1.
REQ-023 load_valid asserted while busy SHALL be ignored, and data_in changes while busy SHALL NOT affect the frame in flight.

Reset
REQ-024 When rst=1 at a rising edge, the next state SHALL be: state IDLE, sdo=1, load_ready=1, busy=0, done=0, counters 0, shift register 0.
REQ-025 Reset SHALL take priority over an accept at the same edge; that word SHALL be dropped.
REQ-026 Reset mid-frame SHALL abort the frame immediately, with no stop bit and no done pulse.

Structure
REQ-027 The FSM state encoding and the frame-overhead constant (3 bits: start, parity, stop) SHALL live in a shared package, ser_pkg.
REQ-028 The bit-period counter SHALL be a sub-module, bit_tick_gen (parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick on the last cycle of each bit period).

Verification
REQ-029 The bench SHALL cover: WIDTH=8, CLKS_PER_BIT=4, accept 0xA5 -> sdo = 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1, each held 4 cycles; done at cycle 44 after accept; load_ready=1 at cycle 45.
REQ-030 The bench SHALL cover: accept 0x07 -> parity bit 1 (three ones); total busy cycles = 44.
REQ-031 The bench SHALL cover: load_valid held high continuously with words 0x11 then 0x22 -> 0x22 accepted exactly one cycle after the first done; the frames are separated by one idle 1.
REQ-032 The bench SHALL cover: rst pulsed at cycle 20 of a frame -> sdo=1, busy=0, load_ready=1 the next cycle; no done pulse.
REQ-033 The bench SHALL cover: CLKS_PER_BIT=1, WIDTH=4, accept 0xF -> frame 0,1,1,1,1,0,1 over 7 consecutive cycles.
REQ-034 The bench SHALL cover: rst and an accept at the same edge -> no frame starts; sdo stays 1.
